// File: rtl/xor3_parity_sequencer.sv
// xor3_parity_sequencer
// Serial parity controller that time-shares one external combinational XOR3
// cell (a,b,c -> f). Each RUN cycle presents {accumulator, bit 2k, bit 2k+1}
// to the cell and registers the returned f, so a WIDTH-bit word is reduced
// in (WIDTH+1)/2 cycles.
// Optional build macro: ODD_PARITY_EN -- final result is inverted (odd parity).
module xor3_parity_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             xf,
    output logic             xa,
    output logic             xb,
    output logic             xc,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    // Two data bits are consumed per step; odd widths get one zero pad bit.
    localparam int NSTEP = (WIDTH + 1) / 2;
    localparam int SHR_W = 2 * NSTEP;
    localparam int CNT_W = $clog2(NSTEP) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic               acc;
    logic [SHR_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;

    // Maps the last XOR3 result onto the reported parity sense.
    function automatic logic final_parity(input logic f);
`ifdef ODD_PARITY_EN
        return ~f;
`else
        return f;
`endif
    endfunction

    // XOR3 operands come straight from registers; forced to 0 outside RUN so
    // the shared cell sees a quiet, well-defined input while idle.
    assign xa = (state == RUN) ? acc      : 1'b0;
    assign xb = (state == RUN) ? shreg[0] : 1'b0;
    assign xc = (state == RUN) ? shreg[1] : 1'b0;

    // Control FSM with registered busy/done/parity; xf is only sampled in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            parity <= 1'b0;
            acc    <= 1'b0;
            shreg  <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= SHR_W'(data_in);
                        acc   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= xf;
                    shreg <= shreg >> 2;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        parity <= final_parity(xf);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor3_parity_sequencer.sv
// Bench for xor3_parity_sequencer: three instances (WIDTH 8, 5, 4), each wired
// to its own mux-built XOR3 cell, checked against a word-level parity model.
module tb_xor3_parity_sequencer;

    localparam bit ODD =
`ifdef ODD_PARITY_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] busy_v, done_v, par_v, xa_v, xb_v, xc_v, xf_v;
    logic [7:0] d8 = '0;
    logic [4:0] d5 = '0;
    logic [3:0] d4 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xor3_parity_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data_in(d8), .xf(xf_v[0]),
        .xa(xa_v[0]), .xb(xb_v[0]), .xc(xc_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .parity(par_v[0]));

    xor3_parity_sequencer #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data_in(d5), .xf(xf_v[1]),
        .xa(xa_v[1]), .xb(xb_v[1]), .xc(xc_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .parity(par_v[1]));

    xor3_parity_sequencer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data_in(d4), .xf(xf_v[2]),
        .xa(xa_v[2]), .xb(xb_v[2]), .xc(xc_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .parity(par_v[2]));

    // Mux-built XOR3 cells: b^c = b ? ~c : c, then a selects inversion.
    for (genvar g = 0; g < 3; g++) begin : g_xor3
        wire bc = xb_v[g] ? ~xc_v[g] : xc_v[g];
        assign xf_v[g] = xa_v[g] ? ~bc : bc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 5 : 4;
    endfunction

    // Reference: reduction XOR of the low n bits of d.
    function automatic logic ref_xor(input logic [63:0] d, input int n);
        logic r = 1'b0;
        for (int i = 0; i < n; i++) r ^= d[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int sel, input logic [63:0] d);
        case (sel)
            0: d8 = d[7:0];
            1: d5 = d[4:0];
            default: d4 = d[3:0];
        endcase
    endtask

    // One complete pass on instance sel, checking operands every step.
    task automatic run_pass(input int sel, input logic [63:0] d_in);
        int w = width_of(sel);
        int ns = (w + 1) / 2;
        logic [63:0] d = d_in & ((64'd1 << w) - 1);
        check("idle_busy", busy_v[sel], 1'b0);
        set_data(sel, d);
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
        set_data(sel, ~d);
        for (int k = 0; k < ns; k++) begin
            check("run_busy", busy_v[sel], 1'b1);
            check("run_done", done_v[sel], 1'b0);
            check("xa", xa_v[sel], ref_xor(d, 2 * k));
            check("xb", xb_v[sel], d[2 * k]);
            check("xc", xc_v[sel], (2 * k + 1 < w) ? d[2 * k + 1] : 1'b0);
            tick();
        end
        check("done_pulse", done_v[sel], 1'b1);
        check("done_busy", busy_v[sel], 1'b0);
        check("parity", par_v[sel], ref_xor(d, w) ^ ODD);
        tick();
        check("done_low", done_v[sel], 1'b0);
        check("parity_hold", par_v[sel], ref_xor(d, w) ^ ODD);
    endtask

    initial begin
        logic exp_p;
        // Reset state
        rst_n = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            check("rst_busy", busy_v[s], 1'b0);
            check("rst_done", done_v[s], 1'b0);
            check("rst_parity", par_v[s], 1'b0);
            check("rst_ops", {xa_v[s], xb_v[s], xc_v[s]}, 3'b000);
        end
        rst_n = 1'b1;
        tick();

        // Directed WIDTH=8 passes
        run_pass(0, 64'hA5);
        run_pass(0, 64'h07);

        // start held high: FF accepted, mid-pass starts ignored, 01 accepted on done cycle
        d8 = 8'hFF;
        start_v[0] = 1'b1;
        tick();
        d8 = 8'h01;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("cont_busy", busy_v[0], 1'b1);
            check("cont_done", done_v[0], 1'b0);
        end
        tick();
        check("cont_done1", done_v[0], 1'b1);
        check("cont_par1", par_v[0], 1'b0 ^ ODD);
        tick();
        check("cont_restart", busy_v[0], 1'b1);
        check("cont_done1_w", done_v[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cont_busy2", busy_v[0], 1'b1);
            check("cont_done2", done_v[0], 1'b0);
        end
        tick();
        start_v[0] = 1'b0;
        check("cont_done2p", done_v[0], 1'b1);
        check("cont_par2", par_v[0], 1'b1 ^ ODD);
        tick();
        check("cont_done2_w", done_v[0], 1'b0);
        tick();

        // Reset mid-pass: make parity 1 first so the clear is observable
        run_pass(0, ODD ? 64'hA5 : 64'h07);
        d8 = 8'h01;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_parity", par_v[0], 1'b0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_nodone", done_v[0], 1'b0);
            check("abort_idle", busy_v[0], 1'b0);
        end
        run_pass(0, 64'h80);

        // WIDTH=5 with pad bit, then exhaustive WIDTH=4
        run_pass(1, 64'b10110);
        for (int v = 0; v < 16; v++) run_pass(2, 64'(v));

        // Randomized passes on the 8- and 5-bit instances with random idle gaps
        for (int i = 0; i < 40; i++) begin
            run_pass(0, 64'($urandom));
            repeat ($urandom_range(0, 2)) tick();
            run_pass(1, 64'($urandom));
        end

        // Parity must hold across idle time
        exp_p = par_v[0];
        repeat (5) tick();
        check("idle_hold", par_v[0], exp_p);
        check("idle_done", done_v[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
